// File: rtl/seg_decoder.sv
// -----------------------------------------------------------------------------
// seg_decoder
//
// Purpose:
//   Decodes a stream of 7-segment patterns into a packed BCD number. Digits
//   are collected until a BLANK delimiter is seen or NDIG digits have
//   arrived. The finished number is then held on the output until the
//   consumer takes it. An invalid pattern discards the number being
//   collected, and every digit after it, up to the next BLANK. Each invalid
//   pattern is flagged with a one-cycle err pulse and counted in a
//   saturating counter.
//
// Parameters:
//   NDIG       maximum number of digits per number (1..8)
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_pat carries a segment pattern
//   in_pat     segment pattern, bit 7 first
//   in_ready   pattern is accepted this cycle (low only while holding output)
//   out_valid  decoded number is presented
//   out_bcd    BCD number; most recent digit in [3:0]; zero when not valid
//   out_count  number of digits in out_bcd; zero when not valid
//   out_ready  consumer takes the number this cycle
//   err        one-cycle pulse after an invalid pattern is accepted
//   err_cnt    saturating count of invalid patterns since reset
//
// States:
//   state | meaning
//   IDLE  | no number in progress; waiting for the first digit
//   ACCUM | collecting digits of a number
//   HOLD  | number complete; presented until out_ready
//   DROP  | invalid pattern seen; discarding up to the next BLANK
// -----------------------------------------------------------------------------
module seg_decoder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_pat,
  output logic              in_ready,
  output logic              out_valid,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [3:0]        out_count,
  input  logic              out_ready,
  output logic              err,
  output logic [7:0]        err_cnt
);

  if (NDIG < 1 || NDIG > 8) begin : g_ndig_check
    $error("seg_decoder: NDIG must be in 1..8");
  end

  localparam logic [3:0] NDIG_CNT = 4'(NDIG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_DIGIT   = 2'd0,
    PAT_BLANK   = 2'd1,
    PAT_INVALID = 2'd2
  } pat_kind_e;

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [3:0]        count_q, count_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  pat_kind_e         pat_kind;
  logic [3:0]        pat_digit;
  logic              accept;
  logic [4*NDIG-1:0] bcd_shift;
  logic [3:0]        count_inc;

  // Pattern decode. The match must be exact, so any pattern with bit 7 set
  // falls through to INVALID.
  always_comb begin
    pat_kind  = PAT_INVALID;
    pat_digit = 4'd0;
    case (in_pat)
      8'h3F: begin pat_kind = PAT_DIGIT; pat_digit = 4'd0; end
      8'h01: begin pat_kind = PAT_DIGIT; pat_digit = 4'd1; end
      8'h41: begin pat_kind = PAT_DIGIT; pat_digit = 4'd2; end
      8'h49: begin pat_kind = PAT_DIGIT; pat_digit = 4'd3; end
      8'h62: begin pat_kind = PAT_DIGIT; pat_digit = 4'd4; end
      8'h5C: begin pat_kind = PAT_DIGIT; pat_digit = 4'd5; end
      8'h52: begin pat_kind = PAT_DIGIT; pat_digit = 4'd6; end
      8'h64: begin pat_kind = PAT_DIGIT; pat_digit = 4'd7; end
      8'h36: begin pat_kind = PAT_DIGIT; pat_digit = 4'd8; end
      8'h76: begin pat_kind = PAT_DIGIT; pat_digit = 4'd9; end
      8'h00: begin pat_kind = PAT_BLANK; pat_digit = 4'd0; end
      default: begin pat_kind = PAT_INVALID; pat_digit = 4'd0; end
    endcase
  end

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + 4'd1;

  // The new digit enters at the bottom nibble and the oldest digit moves up.
  // With a single-digit number there is nothing to shift.
  if (NDIG == 1) begin : g_shift_one
    assign bcd_shift = pat_digit;
  end else begin : g_shift_many
    assign bcd_shift = {bcd_q[4*NDIG-5:0], pat_digit};
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (pat_kind)
            PAT_DIGIT: begin
              bcd_d       = '0;
              bcd_d[3:0]  = pat_digit;
              count_d     = 4'd1;
              state_d     = (NDIG == 1) ? HOLD : ACCUM;
            end
            PAT_INVALID: begin
              err_d   = 1'b1;
              state_d = DROP;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      ACCUM: begin
        if (accept) begin
          case (pat_kind)
            PAT_DIGIT: begin
              bcd_d   = bcd_shift;
              count_d = count_inc;
              if (count_inc == NDIG_CNT) begin
                state_d = HOLD;
              end
            end
            PAT_BLANK: begin
              state_d = HOLD;
            end
            default: begin
              bcd_d   = '0;
              count_d = 4'd0;
              err_d   = 1'b1;
              state_d = DROP;
            end
          endcase
        end
      end

      HOLD: begin
        // in_ready is low here, so no pattern can be accepted on the release
        // edge; the next number starts on the following cycle.
        if (out_ready) begin
          bcd_d   = '0;
          count_d = 4'd0;
          state_d = IDLE;
        end
      end

      DROP: begin
        if (accept) begin
          case (pat_kind)
            PAT_BLANK:   state_d = IDLE;
            PAT_INVALID: err_d   = 1'b1;
            default:     state_d = DROP;
          endcase
        end
      end

      default: begin
        bcd_d   = '0;
        count_d = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? (err_cnt_q + 8'd1) : err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      count_q   <= 4'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // The number is still being built in ACCUM, so it is masked until HOLD.
  assign out_valid = (state_q == HOLD);
  assign out_bcd   = out_valid ? bcd_q : '0;
  assign out_count = out_valid ? count_q : 4'd0;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 Parameter NDIG, default 4, is the maximum digits per number; legal range 1..8.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  is the reset: synchronous, active-low.
REQ-004 in_valid  input  1  indicates that in_pat holds a segment pattern.
REQ-005 in_pat  input  8  is the segment pattern to decode.
REQ-006 in_ready  output  1  indicates the block accepts in_pat this cycle.
REQ-007 out_valid  output  1  indicates that a decoded number is presented.
REQ-008 out_bcd  output  4*NDIG  is the BCD number, most recent digit in bits [3:0], unused upper nibbles 0.
REQ-009 out_count  output  4  is the number of digits in out_bcd (1..NDIG).
REQ-010 out_ready  input  1  indicates the consumer takes the number this cycle.
REQ-011 err  output  1  is a one-cycle pulse when an invalid pattern is accepted.
REQ-012 err_cnt  output  8  is a saturating count of invalid patterns since reset.

Function
REQ-013 Decode table, SHALL be exact, bit 7 first:
- 00111111=0, 00000001=1, 01000001=2, 01001001=3, 01100010=4.
- 01011100=5, 01010010=6, 01100100=7, 00110110=8, 01110110=9.
- 00000000=BLANK (delimiter).
- Any other value is INVALID, including any value with bit 7 = 1.
REQ-014 A pattern is accepted on a rising edge with in_valid=1 and in_ready=1; no other pattern affects state.
REQ-015 FSM states SHALL be IDLE, ACCUM, HOLD and DROP.
REQ-016 in_ready SHALL be 1 in IDLE, ACCUM and DROP, and 0 in HOLD.
REQ-017 IDLE:
- digit d -> bcd={0..,d}, count=1, go to ACCUM (go to HOLD if NDIG=1).
- BLANK -> stay in IDLE, no output.
- INVALID -> go to DROP.
REQ-018 ACCUM:
- digit d -> bcd={bcd[4*NDIG-5:0],d}, count+1; go to HOLD when count reaches NDIG, otherwise stay.
- BLANK -> go to HOLD.
- INVALID -> clear bcd and count, go to DROP.
REQ-019 HOLD: out_valid=1, with out_bcd and out_count held stable until the handshake.
- out_valid=1 and out_ready=1 at an edge -> clear bcd and count, go to IDLE; no pattern is accepted that cycle.
REQ-020 DROP: digits are accepted and discarded; BLANK -> IDLE; INVALID stays in DROP.
REQ-021 Latency: out_valid SHALL rise on the cycle after the edge that accepted the terminating BLANK or NDIG-th digit.
REQ-022 err SHALL be 1 exactly for the cycle after the accepting edge of each INVALID pattern, in any of IDLE, ACCUM or DROP.
REQ-023 err_cnt SHALL increment with each err and saturate at 255.
REQ-024 Back-to-back acceptance SHALL be supported: one pattern per cycle while in_ready=1.
REQ-025 out_bcd and out_count SHALL be 0 whenever out_valid=0.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL enter IDLE with out_valid=0, out_bcd=0, out_count=0, err=0 and err_cnt=0.
- Reset has priority over every handshake.
- A number under accumulation or held mid-handshake is discarded.
REQ-027 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-028 NDIG=4; send 01000001, 01100100, 00000000 -> one cycle later out_valid=1, out_bcd=0x0027, out_count=2; out_ready=1 -> IDLE.
REQ-029 Send 00000001, 01001001, 01011100, 01110110 back-to-back -> out_valid=1, out_bcd=0x1359, out_count=4; in_ready=0 until out_ready.
REQ-030 Send 00111111, 11111111, 00110110, 00000000 -> err pulse one cycle, err_cnt=1, no out_valid; next 00110110, 00000000 -> out_bcd=0x0008.
REQ-031 Send BLANK x3 in IDLE -> no out_valid, no err; then 01010010 with in_valid toggling 1/0 -> one digit accepted only.
REQ-032 Hold out_ready=0 for 10 cycles in HOLD while in_valid=1 -> out_bcd stable and in_valid ignored; assert rst_n=0 mid-HOLD -> all outputs 0 next cycle.
REQ-033 Send 300 INVALID patterns -> err_cnt=255, with err pulsing for each pattern.
